flipper_motion_sequencer: RTL and testbench
===========================================

// Module: flipper_motion_sequencer
// PURPOSE
//  Frame-rate FSM that sequences the dual flipper pair: closes both jaws toward centre on key2,
//  holds while pressed, reopens, then enforces a cooldown. Drives the top-left X of both flipper
//  squares and the kick speed handed to the ball-collision logic. Sits between the key/debounce
//  front end and the flipper draw datapath; all motion advances only on startOfFrame.
// PARAMETERS
//  LEFT_REST_X     200  top-left X of left flipper when fully open
//  RIGHT_REST_X    380  top-left X of right flipper when fully open
//  TRAVEL_X        40   max inward displacement per flipper (pixels), 1..255
//  STEP_X          8    displacement change per frame while moving, 1..TRAVEL_X
//  HOLD_MAX_FRAMES 30   max frames in HOLD before forced reopen
//  COOLDOWN_FRAMES 4    frames in COOLDOWN before re-arm
//  KICK_SPEED      64   signed speedX driven while closing
// PORTS
//  clk            in   1   system clock
//  resetN         in   1   asynchronous active-low reset
//  startOfFrame   in   1   one-clock pulse per video frame; sole motion tick
//  key2IsPressed  in   1   debounced level, 1 = player holding flipper key
//  pause          in   1   level; freezes FSM, counters and outputs
//  reset_level    in   1   level/pulse; synchronous return to rest, beats pause
//  topLeftXLeft   out  11  left flipper X = LEFT_REST_X + offset
//  topLeftXRight  out  11  right flipper X = RIGHT_REST_X - offset
//  speedX         out  32  signed; KICK_SPEED in CLOSING, else 0
//  flipperClosed  out  1   1 while in HOLD
// BEHAVIOUR
//  Reset (resetN=0, async): state=IDLE, offset=0, frameCnt=0, armed=1; outputs = rest X, speedX=0, closed=0.
//  All registers clocked; updates only in cycles where startOfFrame=1 (except reset/reset_level).
//  Outputs registered, valid the cycle after the state/offset update (1 clk latency).
//  Priority per clock: resetN > reset_level (any cycle, same effect as reset) > pause (hold all) > frame tick.
//  armed: cleared on IDLE->CLOSING; set on any startOfFrame with key2IsPressed=0. Prevents auto-repeat.
//  States (transitions evaluated at startOfFrame, pause=0):
//   IDLE:     key2IsPressed && armed -> CLOSING; else stay.
//   CLOSING:  offset = min(offset+STEP_X, TRAVEL_X); when result == TRAVEL_X -> HOLD, frameCnt=0.
//             Key release during CLOSING does not abort; full travel always completed.
//   HOLD:     frameCnt++ each frame; !key2IsPressed -> OPENING; frameCnt == HOLD_MAX_FRAMES-1 -> OPENING
//             (release and timeout same frame: OPENING, single transition).
//   OPENING:  offset = (offset <= STEP_X) ? 0 : offset-STEP_X; when result == 0 -> COOLDOWN, frameCnt=0.
//             Key ignored while opening.
//   COOLDOWN: frameCnt++; frameCnt == COOLDOWN_FRAMES-1 -> IDLE; COOLDOWN_FRAMES=0 treated as 1.
//  Arithmetic: offset 8-bit unsigned, saturating both ends, never wraps; X outputs 11-bit,
//   RIGHT_REST_X >= TRAVEL_X guaranteed by parameter check (elaboration $error otherwise).
//  speedX = 32-bit sign-extended KICK_SPEED iff state==CLOSING, else 0; forced 0 under pause.
//  Pause mid-motion: offset/state frozen, resumes exactly where left on next unpaused frame.
//  reset_level mid-operation: next clock offset=0, state=IDLE, armed=1 (key still held re-triggers on next frame).
// STRUCTURE
//  defines package: typedef enum logic[2:0] {FLIP_IDLE,FLIP_CLOSING,FLIP_HOLD,FLIP_OPENING,FLIP_COOLDOWN}
//   flipper_state_t; constants FLIPPER_LEFT_REST_X, FLIPPER_RIGHT_REST_X, FLIPPER_TRAVEL_X,
//   FLIPPER_STEP_X, FLIPPER_KICK_SPEED used as parameter defaults.
//  Sub-module frame_counter (enable=startOfFrame & ~pause, sync clear, terminal-count compare) reused
//   for HOLD and COOLDOWN timing. FSM and offset saturating adder stay in top.
// TESTING (defaults; frame = startOfFrame pulse)
//  Press held: key=1 at frame 0 -> X L/R = 208/372,216/364,...,240/340 after 5 frames, speedX=64 during, then closed=1, speedX=0.
//  Release in HOLD at frame 10 -> offset 32,24,...,0 over 5 frames, then 4 cooldown frames, IDLE; no retrigger while key held.
//  Hold 40 frames -> forced OPENING after 30 HOLD frames; after cooldown stays IDLE until key released then re-pressed.
//  pause=1 for 3 frames mid-CLOSING at offset 16 -> X stays 216/364, speedX=0; resumes to 24 on first unpaused frame.
//  reset_level=1 with pause=1 in HOLD -> next clk X=200/380, state IDLE, speedX=0.
//  resetN low mid-OPENING (async, no clk edge) -> outputs 200/380, speedX=0, closed=0 immediately.

Source files
------------

// File: rtl/flipper_motion_sequencer_pkg.sv
// Shared state type, default geometry/timing constants and frame-count helpers
// for the flipper motion sequencer.
package flipper_motion_sequencer_pkg;

    typedef enum logic [2:0] {
        FLIP_IDLE,
        FLIP_CLOSING,
        FLIP_HOLD,
        FLIP_OPENING,
        FLIP_COOLDOWN
    } flipper_state_t;

    localparam int FLIPPER_LEFT_REST_X      = 200;
    localparam int FLIPPER_RIGHT_REST_X     = 380;
    localparam int FLIPPER_TRAVEL_X         = 40;
    localparam int FLIPPER_STEP_X           = 8;
    localparam int FLIPPER_HOLD_MAX_FRAMES  = 30;
    localparam int FLIPPER_COOLDOWN_FRAMES  = 4;
    localparam int FLIPPER_KICK_SPEED       = 64;

    localparam int unsigned FLIPPER_CNT_W   = 16;

    // Frame budgets of 0 or 1 both end on the first frame spent in the state.
    function automatic logic [FLIPPER_CNT_W-1:0] frames_to_terminal(input int frames);
        return (frames <= 1) ? '0 : FLIPPER_CNT_W'(frames - 1);
    endfunction

endpackage

// File: rtl/flipper_motion_sequencer_frame_counter.sv
// Frame counter with synchronous clear and terminal-count compare; timing base
// for the HOLD and COOLDOWN durations.
module flipper_motion_sequencer_frame_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count;

    assign at_terminal = (count == terminal);

    // Parks at the terminal value rather than wrapping while the owning state idles.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/flipper_motion_sequencer.sv
// Frame-rate sequencer for the dual flipper pair: close on key2, hold, reopen,
// cool down; drives both flipper X positions and the kick speed.
module flipper_motion_sequencer
    import flipper_motion_sequencer_pkg::*;
#(
    parameter int LEFT_REST_X     = FLIPPER_LEFT_REST_X,
    parameter int RIGHT_REST_X    = FLIPPER_RIGHT_REST_X,
    parameter int TRAVEL_X        = FLIPPER_TRAVEL_X,
    parameter int STEP_X          = FLIPPER_STEP_X,
    parameter int HOLD_MAX_FRAMES = FLIPPER_HOLD_MAX_FRAMES,
    parameter int COOLDOWN_FRAMES = FLIPPER_COOLDOWN_FRAMES,
    parameter int KICK_SPEED      = FLIPPER_KICK_SPEED
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               key2IsPressed,
    input  logic               pause,
    input  logic               reset_level,
    output logic [10:0]        topLeftXLeft,
    output logic [10:0]        topLeftXRight,
    output logic signed [31:0] speedX,
    output logic               flipperClosed
);

    if (RIGHT_REST_X < TRAVEL_X) begin : g_bad_right_rest
        $error("flipper_motion_sequencer: RIGHT_REST_X must be >= TRAVEL_X");
    end
    if (TRAVEL_X < 1 || TRAVEL_X > 255) begin : g_bad_travel
        $error("flipper_motion_sequencer: TRAVEL_X must be in 1..255");
    end
    if (STEP_X < 1 || STEP_X > TRAVEL_X) begin : g_bad_step
        $error("flipper_motion_sequencer: STEP_X must be in 1..TRAVEL_X");
    end

    localparam logic [7:0]               TRAVEL    = 8'(TRAVEL_X);
    localparam logic [7:0]               STEP      = 8'(STEP_X);
    localparam logic [10:0]              LEFT_X0   = 11'(LEFT_REST_X);
    localparam logic [10:0]              RIGHT_X0  = 11'(RIGHT_REST_X);
    localparam logic signed [31:0]       KICK      = 32'(KICK_SPEED);
    localparam logic [FLIPPER_CNT_W-1:0] HOLD_TERM = frames_to_terminal(HOLD_MAX_FRAMES);
    localparam logic [FLIPPER_CNT_W-1:0] COOL_TERM = frames_to_terminal(COOLDOWN_FRAMES);

    flipper_state_t state_q, state_d;
    logic [7:0]     offset_q, offset_d;
    logic           armed_q, armed_d;
    logic           tick;
    logic           cnt_clear;
    logic           cnt_done;
    logic [8:0]     close_sum;
    logic [7:0]     close_next;
    logic [7:0]     open_next;

    assign tick = startOfFrame & ~pause;

    // Saturating in both directions; the 9-bit sum keeps the upper clamp wrap-free.
    assign close_sum  = {1'b0, offset_q} + {1'b0, STEP};
    assign close_next = (close_sum >= {1'b0, TRAVEL}) ? TRAVEL : close_sum[7:0];
    assign open_next  = (offset_q <= STEP) ? '0 : offset_q - STEP;

    flipper_motion_sequencer_frame_counter #(
        .WIDTH (FLIPPER_CNT_W)
    ) u_frame_counter (
        .clk         (clk),
        .resetN      (resetN),
        .clear       (cnt_clear | reset_level),
        .enable      (tick),
        .terminal    ((state_q == FLIP_HOLD) ? HOLD_TERM : COOL_TERM),
        .at_terminal (cnt_done)
    );

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        armed_d   = armed_q;
        cnt_clear = 1'b0;
        if (tick) begin
            if (!key2IsPressed) begin
                armed_d = 1'b1;
            end
            case (state_q)
                FLIP_IDLE: begin
                    if (key2IsPressed && armed_q) begin
                        state_d = FLIP_CLOSING;
                        armed_d = 1'b0;
                    end
                end
                FLIP_CLOSING: begin
                    offset_d = close_next;
                    if (close_next == TRAVEL) begin
                        state_d   = FLIP_HOLD;
                        cnt_clear = 1'b1;
                    end
                end
                FLIP_HOLD: begin
                    if (!key2IsPressed || cnt_done) begin
                        state_d = FLIP_OPENING;
                    end
                end
                FLIP_OPENING: begin
                    offset_d = open_next;
                    if (open_next == '0) begin
                        state_d   = FLIP_COOLDOWN;
                        cnt_clear = 1'b1;
                    end
                end
                FLIP_COOLDOWN: begin
                    if (cnt_done) begin
                        state_d = FLIP_IDLE;
                    end
                end
                default: state_d = FLIP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= FLIP_IDLE;
            offset_q <= '0;
            armed_q  <= 1'b1;
        end else if (reset_level) begin
            state_q  <= FLIP_IDLE;
            offset_q <= '0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            armed_q  <= armed_d;
        end
    end

    // Output registers are cleared directly by reset_level so rest X appears on the next clock.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            topLeftXLeft  <= LEFT_X0;
            topLeftXRight <= RIGHT_X0;
            speedX        <= '0;
            flipperClosed <= 1'b0;
        end else if (reset_level) begin
            topLeftXLeft  <= LEFT_X0;
            topLeftXRight <= RIGHT_X0;
            speedX        <= '0;
            flipperClosed <= 1'b0;
        end else begin
            topLeftXLeft  <= LEFT_X0 + {3'b000, offset_q};
            topLeftXRight <= RIGHT_X0 - {3'b000, offset_q};
            speedX        <= (state_q == FLIP_CLOSING && !pause) ? KICK : '0;
            flipperClosed <= (state_q == FLIP_HOLD);
        end
    end

endmodule

// File: tb/tb_flipper_motion_sequencer.sv
// Directed and randomized checks of flipper_motion_sequencer against a
// frame-level behavioural model of the flipper motion.
module tb_flipper_motion_sequencer;

    localparam int L_REST   = 200;
    localparam int R_REST   = 380;
    localparam int TRAVEL   = 40;
    localparam int STEP     = 8;
    localparam int HOLD_MAX = 30;
    localparam int COOL     = 4;
    localparam int KICK     = 64;

    logic               clk = 1'b0;
    logic               resetN = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               key2IsPressed = 1'b0;
    logic               pause = 1'b0;
    logic               reset_level = 1'b0;
    logic [10:0]        topLeftXLeft;
    logic [10:0]        topLeftXRight;
    logic signed [31:0] speedX;
    logic               flipperClosed;

    int n_asserts = 0;
    int n_fails   = 0;

    // Behavioural model: motion phase name, jaw displacement, frames left in phase.
    string m_phase;
    int    m_off;
    int    m_left;
    bit    m_armed;

    flipper_motion_sequencer #(
        .LEFT_REST_X     (L_REST),
        .RIGHT_REST_X    (R_REST),
        .TRAVEL_X        (TRAVEL),
        .STEP_X          (STEP),
        .HOLD_MAX_FRAMES (HOLD_MAX),
        .COOLDOWN_FRAMES (COOL),
        .KICK_SPEED      (KICK)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .key2IsPressed (key2IsPressed),
        .pause         (pause),
        .reset_level   (reset_level),
        .topLeftXLeft  (topLeftXLeft),
        .topLeftXRight (topLeftXRight),
        .speedX        (speedX),
        .flipperClosed (flipperClosed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_asserts++;
        assert (got === want) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(want));
        end
    endtask

    task automatic model_reset();
        m_phase = "idle";
        m_off   = 0;
        m_left  = 0;
        m_armed = 1'b1;
    endtask

    task automatic model_frame(input bit key, input bit p);
        if (p) return;
        if (!key) m_armed = 1'b1;
        if (m_phase == "idle") begin
            if (key && m_armed) begin
                m_phase = "close";
                m_armed = 1'b0;
            end
        end else if (m_phase == "close") begin
            m_off = (m_off + STEP > TRAVEL) ? TRAVEL : m_off + STEP;
            if (m_off == TRAVEL) begin
                m_phase = "hold";
                m_left  = (HOLD_MAX < 1) ? 1 : HOLD_MAX;
            end
        end else if (m_phase == "hold") begin
            m_left--;
            if (!key || m_left == 0) m_phase = "open";
        end else if (m_phase == "open") begin
            m_off = (m_off > STEP) ? m_off - STEP : 0;
            if (m_off == 0) begin
                m_phase = "cool";
                m_left  = (COOL < 1) ? 1 : COOL;
            end
        end else if (m_phase == "cool") begin
            m_left--;
            if (m_left == 0) m_phase = "idle";
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".xl"}, 32'(topLeftXLeft), 32'(L_REST + m_off));
        chk({tag, ".xr"}, 32'(topLeftXRight), 32'(R_REST - m_off));
        chk({tag, ".spd"}, speedX, (m_phase == "close" && !pause) ? 32'(KICK) : 32'd0);
        chk({tag, ".closed"}, 32'(flipperClosed), (m_phase == "hold") ? 32'd1 : 32'd0);
    endtask

    // One frame pulse, then two clocks for state and output registers to settle.
    task automatic frame(input bit key, input bit p, input string tag);
        @(negedge clk);
        startOfFrame  = 1'b1;
        key2IsPressed = key;
        pause         = p;
        @(negedge clk);
        startOfFrame = 1'b0;
        model_frame(key, p);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic pulse_reset_level(input bit p);
        @(negedge clk);
        reset_level = 1'b1;
        pause       = p;
        @(negedge clk);
        reset_level = 1'b0;
        model_reset();
        check_model("reset_level");
    endtask

    initial begin
        bit key_r;
        model_reset();

        #3 resetN = 1'b0;
        #1;
        chk("reset.xl", 32'(topLeftXLeft), 32'd200);
        chk("reset.xr", 32'(topLeftXRight), 32'd380);
        chk("reset.spd", speedX, 32'd0);
        chk("reset.closed", 32'(flipperClosed), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        frame(1'b0, 1'b0, "idle");

        // Press and hold: five closing frames, then HOLD.
        frame(1'b1, 1'b0, "press_f0");
        chk("press_f0.spd", speedX, 32'd64);
        frame(1'b1, 1'b0, "press_f1");
        chk("press_f1.xl", 32'(topLeftXLeft), 32'd208);
        chk("press_f1.xr", 32'(topLeftXRight), 32'd372);
        for (int i = 2; i <= 5; i++) frame(1'b1, 1'b0, "closing");
        chk("closed.xl", 32'(topLeftXLeft), 32'd240);
        chk("closed.xr", 32'(topLeftXRight), 32'd340);
        chk("closed.spd", speedX, 32'd0);
        chk("closed.flag", 32'(flipperClosed), 32'd1);
        for (int i = 6; i <= 9; i++) frame(1'b1, 1'b0, "hold");
        frame(1'b0, 1'b0, "release");
        for (int i = 11; i <= 25; i++) frame(1'b0, 1'b0, "reopen");
        chk("reopened.xl", 32'(topLeftXLeft), 32'd200);
        chk("reopened.closed", 32'(flipperClosed), 32'd0);

        // Held 52 frames: forced reopen after 30 HOLD frames, no auto-repeat.
        for (int i = 0; i < 52; i++) begin
            frame(1'b1, 1'b0, "long_hold");
            if (i == 34) chk("timeout_last_hold", 32'(flipperClosed), 32'd1);
            if (i == 35) chk("timeout_forced_open", 32'(flipperClosed), 32'd0);
        end
        chk("no_repeat.xl", 32'(topLeftXLeft), 32'd200);
        chk("no_repeat.spd", speedX, 32'd0);
        frame(1'b0, 1'b0, "rearm");
        frame(1'b1, 1'b0, "repress");
        chk("repress.spd", speedX, 32'd64);

        // Pause mid-closing at offset 16.
        frame(1'b1, 1'b0, "pre_pause");
        frame(1'b1, 1'b0, "pre_pause");
        for (int i = 0; i < 3; i++) begin
            frame(1'b1, 1'b1, "paused");
            chk("paused.xl", 32'(topLeftXLeft), 32'd216);
            chk("paused.xr", 32'(topLeftXRight), 32'd364);
            chk("paused.spd", speedX, 32'd0);
        end
        frame(1'b1, 1'b0, "resume");
        chk("resume.xl", 32'(topLeftXLeft), 32'd224);
        for (int i = 0; i < 4; i++) frame(1'b1, 1'b0, "to_hold");

        // reset_level beats pause while in HOLD; held key re-triggers.
        pulse_reset_level(1'b1);
        chk("rl.xl", 32'(topLeftXLeft), 32'd200);
        chk("rl.xr", 32'(topLeftXRight), 32'd380);
        frame(1'b1, 1'b0, "rl_retrigger");
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, "rl_close");
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, "rl_open");

        // Asynchronous reset mid-opening, away from any clock edge.
        #2 resetN = 1'b0;
        #1;
        chk("areset.xl", 32'(topLeftXLeft), 32'd200);
        chk("areset.xr", 32'(topLeftXRight), 32'd380);
        chk("areset.spd", speedX, 32'd0);
        chk("areset.closed", 32'(flipperClosed), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        model_reset();

        // Randomized key runs with occasional pause and reset_level.
        key_r = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) key_r = ~key_r;
            if ($urandom_range(0, 49) == 0) pulse_reset_level(1'($urandom_range(0, 1)));
            frame(key_r, ($urandom_range(0, 7) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
